// File: rtl/huffman_pkg.sv
// Shared definitions for the canonical Huffman datapath: symbol buffer geometry
// and the loader state encoding used by the loader, encoder and output dump.
`timescale 1ns/1ps
package huffman_pkg;

  localparam int SYM_W     = 8;
  localparam int BUF_DEPTH = 256;
  localparam int BUF_AW    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/huffman_symbol_loader.sv
// Accepts a valid/ready byte stream and writes it into the external symbol RAM,
// reporting frame length and completion (in_last or buffer full) to the encoder.
`timescale 1ns/1ps
module huffman_symbol_loader
  import huffman_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int AW    = BUF_AW,
  parameter int DW    = SYM_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [AW:0]   load_len,
  output logic          done,
  output logic          busy,
  output logic          trunc
);

  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  ld_state_e     state_q;
  logic [AW:0]   cnt_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic [AW:0]   load_len_q;
  logic          done_q;
  logic          trunc_q;

  logic          xfer_s;
  logic          fill_s;
  logic [AW:0]   cnt_d;

  // Handshake decode: in_ready comes from the state register alone.
  always_comb begin
    in_ready = (state_q == ST_LOAD);
    busy     = (state_q == ST_LOAD);
    xfer_s   = in_valid & (state_q == ST_LOAD);
    fill_s   = (cnt_q == LAST_IDX);
    cnt_d    = cnt_q + ONE;
  end

  // Loader FSM with registered write port and frame status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      load_len_q <= '0;
      done_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // A byte offered alongside start is not consumed: in_ready is still 0.
          if (start) begin
            state_q    <= ST_LOAD;
            cnt_q      <= '0;
            load_len_q <= '0;
            done_q     <= 1'b0;
            trunc_q    <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (xfer_s) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q[AW-1:0];
            wr_data_q <= in_data;
            cnt_q     <= cnt_d;
            if (in_last || fill_s) begin
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              load_len_q <= cnt_d;
              trunc_q    <= ~in_last;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign load_len = load_len_q;
  assign done     = done_q;
  assign trunc    = trunc_q;

endmodule

// File: tb/tb_huffman_symbol_loader.sv
// Self-checking bench for huffman_symbol_loader: table of frame vectors, random
// frames against a frame-level model, plus reset and start-collision sequences.
`timescale 1ns/1ps
module tb_huffman_symbol_loader;
  import huffman_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   load_len;
  logic          done;
  logic          busy;
  logic          trunc;

  huffman_symbol_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_len(load_len), .done(done), .busy(busy), .trunc(trunc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] cap_addr[$];
  logic [7:0] cap_data[$];
  logic       cap_done[$];

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
      cap_done.push_back(done);
    end
  end

  typedef struct {
    int         n;
    logic [7:0] base;
    bit         last;
    bit         gaps;
    int         mid;
    int         exp_len;
    bit         exp_trunc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_cap();
    cap_addr.delete();
    cap_data.delete();
    cap_done.delete();
  endtask

  // All tasks start and end 1ns after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input bit last,
                            input bit gaps, input int mid);
    int acc;
    int w;
    acc = (n < DEPTH) ? n : DEPTH;
    clear_cap();
    pulse_start();
    chk("ready_after_start", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < acc; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      in_last  = last && (i == n - 1);
      if (i == mid) start = 1'b1;
      w = 0;
      while (in_ready !== 1'b1 && w < 8) begin
        @(posedge clk); #1;
        w++;
      end
      if (w >= 8) begin
        chk("handshake_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (n > acc) begin
      in_valid = 1'b1;
      in_data  = base + 8'(acc);
      in_last  = last;
      repeat (3) begin @(posedge clk); #1; end
      chk("held_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_frame(input logic [7:0] base, input int exp_len, input bit exp_trunc);
    int bad;
    int bad_done;
    chk("done", {31'd0, done}, 32'd1);
    chk("load_len", {23'd0, load_len}, 32'(exp_len));
    chk("trunc", {31'd0, trunc}, {31'd0, exp_trunc});
    chk("ready_in_done", {31'd0, in_ready}, 32'd0);
    chk("write_count", 32'(cap_addr.size()), 32'(exp_len));
    bad = 0;
    bad_done = 0;
    for (int i = 0; i < cap_addr.size(); i++) begin
      if (cap_addr[i] !== 8'(i)) bad++;
      if (cap_data[i] !== base + 8'(i)) bad++;
      if (cap_done[i] !== (i == cap_addr.size() - 1)) bad_done++;
    end
    chk("write_contents", 32'(bad), 32'd0);
    chk("done_with_last_write", 32'(bad_done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3,   8'h41, 1'b1, 1'b0, -1, 3,   1'b0};
    vecs[1] = '{257, 8'h00, 1'b0, 1'b0, -1, 256, 1'b1};
    vecs[2] = '{256, 8'h00, 1'b1, 1'b0, -1, 256, 1'b0};
    vecs[3] = '{10,  8'h80, 1'b1, 1'b1, -1, 10,  1'b0};
    vecs[4] = '{8,   8'h20, 1'b1, 1'b0, 5,  8,   1'b0};
    vecs[5] = '{1,   8'hF0, 1'b1, 1'b0, -1, 1,   1'b0};
    vecs[6] = '{255, 8'h33, 1'b1, 1'b1, -1, 255, 1'b0};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    #12;
    chk("reset_outputs",
        {9'd0, in_ready, wr_en, wr_addr, wr_data, load_len, done, busy, trunc}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("idle_ready", {31'd0, in_ready}, 32'd0);
    chk("idle_no_write", 32'(cap_addr.size()), 32'd0);
    in_valid = 1'b0;

    foreach (vecs[k]) begin
      send_frame(vecs[k].n, vecs[k].base, vecs[k].last, vecs[k].gaps, vecs[k].mid);
      check_frame(vecs[k].base, vecs[k].exp_len, vecs[k].exp_trunc);
    end

    // Randomised frames against the frame-level model.
    for (int r = 0; r < 6; r++) begin
      int         n;
      bit         last;
      logic [7:0] base;
      int         el;
      bit         et;
      n    = $urandom_range(1, 300);
      last = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      base = 8'($urandom_range(0, 255));
      el   = (n < DEPTH) ? n : DEPTH;
      et   = !(last && n <= DEPTH);
      send_frame(n, base, last, 1'b1, -1);
      check_frame(base, el, et);
    end

    // Start coinciding with a valid byte in DONE: that byte is dropped.
    clear_cap();
    start = 1'b1; in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_data = 8'h55;
    chk("done_drops_after_start", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("collide_len", {23'd0, load_len}, 32'd1);
    chk("collide_count", 32'(cap_data.size()), 32'd1);
    if (cap_data.size() == 1) chk("collide_data", {24'd0, cap_data[0]}, 32'h55);

    // Reset in the middle of a frame, then a fresh 2-byte frame.
    send_frame(100, 8'h00, 1'b0, 1'b0, -1);
    chk("partial_busy", {31'd0, busy}, 32'd1);
    chk("partial_no_done", {31'd0, done}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("midframe_reset_outputs",
        {9'd0, in_ready, wr_en, wr_addr, wr_data, load_len, done, busy, trunc}, 32'd0);
    @(posedge clk); #1;
    chk("reset_held_outputs", {29'd0, done, busy, in_ready}, 32'd0);
    reset = 1'b0;
    send_frame(2, 8'hC0, 1'b1, 1'b0, -1);
    check_frame(8'hC0, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
